// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions: packet opcodes plus the address and packet layout macros.
// Packet fields, MSB first: addr, op, op_ex, payload, src_y_cord, src_x_cord, y_cord, x_cord.
`ifndef BSG_MANYCORE_PKG_MACROS
`define BSG_MANYCORE_PKG_MACROS
`define BSG_MANYCORE_PACKET_WIDTH(addr_w, data_w, x_w, y_w) ((addr_w) + 2 + ((data_w) / 8) + (data_w) + 2 * ((x_w) + (y_w)))
`define DECLARE_BSG_MANYCORE_ADDR_S(x_w, y_w) typedef struct packed { logic remote; logic [(y_w)-1:0] y_cord; logic [(x_w)-1:0] x_cord; logic [30-(x_w)-(y_w):0] addr; } bsg_manycore_addr_s
`define DECLARE_BSG_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w) typedef struct packed { logic [(addr_w)-1:0] addr; logic [1:0] op; logic [((data_w)/8)-1:0] op_ex; logic [(data_w)-1:0] payload; logic [(y_w)-1:0] src_y_cord; logic [(x_w)-1:0] src_x_cord; logic [(y_w)-1:0] y_cord; logic [(x_w)-1:0] x_cord; } bsg_manycore_packet_s
`endif

package bsg_manycore_pkg;

  localparam int manycore_addr_width_gp = 32;

  typedef enum logic [1:0] {
    e_remote_load    = 2'd0,
    e_remote_store   = 2'd1,
    e_remote_swap_aq = 2'd2,
    e_remote_swap_rl = 2'd3
  } bsg_manycore_packet_op_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small first-word-fall-through FIFO: the head is readable combinationally while v_o is high.
// ready_o depends only on occupancy, never on yumi_i, so producers see no combinational path.
module bsg_fifo_1r1w_small #(
  parameter int width_p = -1,
  parameter int els_p = 2,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

  logic [width_p-1:0] mem_reg [els_p];
  logic [ptr_width_lp-1:0] rptr_reg, wptr_reg;
  logic [count_width_lp-1:0] count_reg;
  logic enq, deq;

  assign ready_o = (count_reg != full_count_lp);
  assign v_o     = (count_reg != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_reg[rptr_reg];

  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wptr_reg] <= data_i;
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) wptr_reg <= (wptr_reg == last_ptr_lp) ? '0 : wptr_reg + ptr_width_lp'(1);
      if (deq) rptr_reg <= (rptr_reg == last_ptr_lp) ? '0 : rptr_reg + ptr_width_lp'(1);
      if (enq & ~deq)      count_reg <= count_reg + count_width_lp'(1);
      else if (deq & ~enq) count_reg <= count_reg - count_width_lp'(1);
    end
  end

endmodule

// File: rtl/bsg_manycore_pkt_encode_buffered.sv
// Encodes core requests into manycore packets, buffers them and tracks outstanding remote credits.
// Define BSG_MANYCORE_PKT_ENCODE_STATS_EN to build the sent-packet counter behind stats_sent_o.
module bsg_manycore_pkt_encode_buffered
  import bsg_manycore_pkg::*;
#(
  parameter int x_cord_width_p = -1,
  parameter int y_cord_width_p = -1,
  parameter int data_width_p = -1,
  parameter int addr_width_p = -1,
  parameter int els_p = 2,
  parameter int max_out_credits_p = 16,
  localparam int packet_width_lp = `BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [31:0]                addr_i,
  input  logic [data_width_p-1:0]    data_i,
  input  logic [data_width_p/8-1:0]  mask_i,
  input  logic                       we_i,
  input  logic                       swap_aq_i,
  input  logic                       swap_rl_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  output logic                       local_v_o,
  output logic                       pkt_v_o,
  output logic [packet_width_lp-1:0] pkt_o,
  input  logic                       pkt_yumi_i,
  input  logic                       credit_v_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       error_o,
  output logic [31:0]                stats_sent_o
);

  `DECLARE_BSG_MANYCORE_ADDR_S(x_cord_width_p, y_cord_width_p);
  `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

  localparam int addr_field_width_lp = 31 - x_cord_width_p - y_cord_width_p;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  bsg_manycore_addr_s   addr_s;
  bsg_manycore_packet_s pkt_enc;
  logic armed_reg, error_reg, error_set;
  logic [credit_width_lp-1:0] credits_reg, credits_next;
  logic fifo_ready, is_swap, accept, deq, credit_in, credit_overflow;

  assign addr_s  = addr_i;
  assign is_swap = swap_aq_i | swap_rl_i;

  // armed_reg keeps the first edge after reset inert so every output still shows its reset value.
  assign ready_o   = armed_reg & fifo_ready & (credits_reg != '0);
  assign accept    = v_i & addr_s.remote & ready_o;
  assign local_v_o = v_i & ~addr_s.remote & ~is_swap;
  assign deq       = pkt_yumi_i & pkt_v_o;
  assign credit_in = credit_v_i & armed_reg;

  if (addr_field_width_lp > addr_width_p) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = |addr_s.addr[addr_field_width_lp-1:addr_width_p];
  end

  always_comb begin
    pkt_enc      = '0;
    pkt_enc.addr = addr_s.addr[addr_width_p-1:0];
    if (swap_aq_i)      pkt_enc.op = e_remote_swap_aq;
    else if (swap_rl_i) pkt_enc.op = e_remote_swap_rl;
    else if (we_i)      pkt_enc.op = e_remote_store;
    else                pkt_enc.op = e_remote_load;
    pkt_enc.op_ex      = mask_i;
    pkt_enc.payload    = data_i;
    pkt_enc.src_y_cord = my_y_i;
    pkt_enc.src_x_cord = my_x_i;
    pkt_enc.y_cord     = addr_s.y_cord;
    pkt_enc.x_cord     = addr_s.x_cord;
  end

  bsg_fifo_1r1w_small #(
    .width_p(packet_width_lp),
    .els_p  (els_p)
  ) buffer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (accept),
    .ready_o(fifo_ready),
    .data_i (pkt_enc),
    .v_o    (pkt_v_o),
    .data_o (pkt_o),
    .yumi_i (deq)
  );

  // A returned credit with nothing outstanding is a protocol error; the count stays saturated.
  assign credit_overflow = credit_in & ~accept & (credits_reg == max_credits_lp);
  assign error_set = credit_overflow | (armed_reg & v_i & ~addr_s.remote & is_swap);

  always_comb begin
    credits_next = credits_reg;
    if (accept & ~credit_in)
      credits_next = credits_reg - credit_width_lp'(1);
    else if (credit_in & ~accept & ~credit_overflow)
      credits_next = credits_reg + credit_width_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      armed_reg   <= 1'b0;
      credits_reg <= max_credits_lp;
      error_reg   <= 1'b0;
    end else begin
      armed_reg   <= 1'b1;
      credits_reg <= credits_next;
      if (error_set) error_reg <= 1'b1;
    end
  end

  assign out_credits_o = credits_reg;
  assign error_o       = error_reg;

`ifdef BSG_MANYCORE_PKT_ENCODE_STATS_EN
  logic [31:0] stats_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)  stats_reg <= '0;
    else if (deq) stats_reg <= stats_reg + 32'd1;
  end

  assign stats_sent_o = stats_reg;
`else
  assign stats_sent_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_encode_buffered.sv
// Bench for bsg_manycore_pkt_encode_buffered with x=y=4, addr 20, data 32, els 2, 16 credits.
// Encoding vector table, hand sequences for buffer/credit/reset corners, then random traffic vs a queue model.
module tb_bsg_manycore_pkt_encode_buffered;

  localparam int XW = 4, YW = 4, DW = 32, AW = 20, ELS = 2, MAXC = 16;
  localparam int PW = AW + 2 + DW / 8 + DW + 2 * (XW + YW);
  localparam int CW = $clog2(MAXC + 1);

`ifdef BSG_MANYCORE_PKT_ENCODE_STATS_EN
  localparam logic [31:0] STATS3 = 32'd3;
`else
  localparam logic [31:0] STATS3 = 32'd0;
`endif

  logic clk_i = 1'b0;
  logic reset_i;
  logic v_i, ready_o, we_i, swap_aq_i, swap_rl_i, local_v_o;
  logic pkt_v_o, pkt_yumi_i, credit_v_i, error_o;
  logic [31:0] addr_i, data_i, stats_sent_o;
  logic [3:0] mask_i, my_x_i, my_y_i;
  logic [PW-1:0] pkt_o;
  logic [CW-1:0] out_credits_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of expected packets, credit count, sticky error, sent count.
  logic [PW-1:0] exp_q [$];
  int cred_m, stats_m;
  bit err_m, armed_m;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    bit          we, aq, rl, v;
    logic [3:0]  mx, my;
    bit          exp_local, exp_enq;
    logic [1:0]  exp_op;
    logic [3:0]  exp_y, exp_x;
    logic [19:0] exp_addr;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  always #5 clk_i = ~clk_i;

  bsg_manycore_pkt_encode_buffered #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
    .els_p(ELS), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .addr_i(addr_i),
    .data_i(data_i), .mask_i(mask_i), .we_i(we_i), .swap_aq_i(swap_aq_i), .swap_rl_i(swap_rl_i),
    .my_x_i(my_x_i), .my_y_i(my_y_i), .local_v_o(local_v_o), .pkt_v_o(pkt_v_o), .pkt_o(pkt_o),
    .pkt_yumi_i(pkt_yumi_i), .credit_v_i(credit_v_i), .out_credits_o(out_credits_o),
    .error_o(error_o), .stats_sent_o(stats_sent_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] encode(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                                           input bit we, input bit aq, input bit rl,
                                           input logic [3:0] mx, input logic [3:0] my);
    logic [1:0] op;
    logic [3:0] y, x;
    logic [19:0] off;
    op  = aq ? 2'd2 : rl ? 2'd3 : we ? 2'd1 : 2'd0;
    y   = 4'((a >> 27) % 16);
    x   = 4'((a >> 23) % 16);
    off = 20'(a % (32'd1 << 20));
    return {off, op, m, d, my, mx, y, x};
  endfunction

  task automatic check_state();
    logic [31:0] exp_stats;
`ifdef BSG_MANYCORE_PKT_ENCODE_STATS_EN
    exp_stats = 32'(stats_m);
`else
    exp_stats = 32'd0;
`endif
    check("pkt_v_o", pkt_v_o, exp_q.size() > 0);
    if (exp_q.size() > 0) check("pkt_o", pkt_o, exp_q[0]);
    check("out_credits_o", out_credits_o, cred_m);
    check("error_o", error_o, err_m);
    check("stats_sent_o", stats_sent_o, exp_stats);
  endtask

  // One clock of stimulus: combinational outputs checked before the edge, state after it.
  task automatic run_cycle(input bit v, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                           input bit we, input bit aq, input bit rl, input bit yumi, input bit credit);
    bit exp_ready, remote, accept;
    v_i = v; addr_i = addr; data_i = data; mask_i = mask;
    we_i = we; swap_aq_i = aq; swap_rl_i = rl;
    pkt_yumi_i = yumi; credit_v_i = credit;
    #1;
    remote    = addr[31];
    exp_ready = armed_m && (exp_q.size() < ELS) && (cred_m > 0);
    check("ready_o", ready_o, exp_ready);
    check("local_v_o", local_v_o, v && !remote && !aq && !rl);
    accept = v && remote && exp_ready;
    if (armed_m) begin
      if (yumi && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        stats_m++;
      end
      if (accept) exp_q.push_back(encode(addr, data, mask, we, aq, rl, my_x_i, my_y_i));
      cred_m = cred_m - int'(accept) + int'(credit);
      if (cred_m > MAXC) begin
        cred_m = MAXC;
        err_m  = 1'b1;
      end
      if (v && !remote && (aq || rl)) err_m = 1'b1;
    end
    armed_m = 1'b1;
    @(posedge clk_i); #1;
    check_state();
  endtask

  task automatic idle(input bit yumi, input bit credit);
    run_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, yumi, credit);
  endtask

  task automatic do_reset();
    v_i = 0; we_i = 0; swap_aq_i = 0; swap_rl_i = 0; pkt_yumi_i = 0; credit_v_i = 0;
    #2 reset_i = 1'b1;
    #1;
    check("rst_pkt_v", pkt_v_o, 0);
    check("rst_credits", out_credits_o, MAXC);
    check("rst_error", error_o, 0);
    check("rst_stats", stats_sent_o, 0);
    exp_q.delete();
    cred_m = MAXC; err_m = 0; stats_m = 0; armed_m = 0;
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h8120_0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 1, 4'd1, 4'd3, 0, 1, 2'd1, 4'd0, 4'd2, 20'h00010};
    vecs[1] = '{32'h9A7F_FFFF, 32'h0BAD_F00D, 4'h3, 0, 0, 0, 1, 4'd2, 4'd5, 0, 1, 2'd0, 4'd3, 4'd4, 20'hFFFFF};
    vecs[2] = '{32'hFFFF_FFFF, 32'h5555_AAAA, 4'h8, 1, 0, 1, 1, 4'd15, 4'd0, 0, 1, 2'd3, 4'd15, 4'd15, 20'hFFFFF};
    vecs[3] = '{32'h8000_0000, 32'h1357_9BDF, 4'h1, 1, 1, 1, 1, 4'd0, 4'd15, 0, 1, 2'd2, 4'd0, 4'd0, 20'h00000};
    vecs[4] = '{32'h0000_0040, 32'h0000_0000, 4'hF, 0, 0, 0, 1, 4'd1, 4'd3, 1, 0, 2'd0, 4'd0, 4'd0, 20'h00000};
    vecs[5] = '{32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 1, 4'd1, 4'd3, 1, 0, 2'd0, 4'd0, 4'd0, 20'h00000};
    vecs[6] = '{32'hC0A5_5AA5, 32'h1234_5678, 4'h5, 1, 0, 0, 1, 4'd7, 4'd9, 0, 1, 2'd1, 4'd8, 4'd1, 20'h55AA5};
    vecs[7] = '{32'h8120_0010, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, 4'd1, 4'd3, 0, 0, 2'd0, 4'd0, 4'd0, 20'h00000};

    reset_i = 1'b1; v_i = 0; addr_i = 0; data_i = 0; mask_i = 0; we_i = 0;
    swap_aq_i = 0; swap_rl_i = 0; pkt_yumi_i = 0; credit_v_i = 0; my_x_i = 4'd1; my_y_i = 4'd3;
    @(posedge clk_i); #1;
    do_reset();

    // First edge after reset: a remote store and a credit must both be ignored.
    run_cycle(1, 32'h8120_0010, 32'h1, 4'hF, 1, 0, 0, 0, 1);
    check("hold_pkt_v", pkt_v_o, 0);
    check("hold_error", error_o, 0);

    for (int i = 0; i < NV; i++) begin
      my_x_i = vecs[i].mx; my_y_i = vecs[i].my;
      run_cycle(vecs[i].v, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].we, vecs[i].aq, vecs[i].rl,
                exp_q.size() > 0, 0);
      check($sformatf("vec%0d_local", i), local_v_o, vecs[i].exp_local);
      check($sformatf("vec%0d_pkt_v", i), pkt_v_o, vecs[i].exp_enq);
      if (vecs[i].exp_enq) begin
        check($sformatf("vec%0d_op", i), pkt_o[53:52], vecs[i].exp_op);
        check($sformatf("vec%0d_y", i), pkt_o[7:4], vecs[i].exp_y);
        check($sformatf("vec%0d_x", i), pkt_o[3:0], vecs[i].exp_x);
        check($sformatf("vec%0d_addr", i), pkt_o[73:54], vecs[i].exp_addr);
        check($sformatf("vec%0d_src", i), pkt_o[15:8], {vecs[i].my, vecs[i].mx});
        check($sformatf("vec%0d_data", i), pkt_o[47:16], vecs[i].data);
        check($sformatf("vec%0d_mask", i), pkt_o[51:48], vecs[i].mask);
      end
      if (i == 0) check("vec0_credits", out_credits_o, 15);
    end
    my_x_i = 4'd1; my_y_i = 4'd3;
    idle(exp_q.size() > 0, 0);

    // Buffer fill with no yumi: two accepts, then backpressure, then exactly one more after a yumi.
    do_reset();
    idle(0, 0);
    for (int k = 0; k < 4; k++) run_cycle(1, 32'h8120_0010, 32'hA000_0000 + k, 4'hF, 1, 0, 0, 0, 0);
    check("full_ready", ready_o, 0);
    run_cycle(1, 32'h8120_0010, 32'hA000_0004, 4'hF, 1, 0, 0, 1, 0);
    run_cycle(1, 32'h8120_0010, 32'hA000_0005, 4'hF, 1, 0, 0, 0, 0);
    run_cycle(1, 32'h8120_0010, 32'hA000_0006, 4'hF, 1, 0, 0, 0, 0);
    check("order_head0", pkt_o[47:16], 32'hA000_0001);
    idle(1, 0);
    check("order_head1", pkt_o[47:16], 32'hA000_0005);
    idle(1, 0);
    check("drained", pkt_v_o, 0);

    // Credit exhaustion and recovery.
    do_reset();
    idle(0, 0);
    for (int k = 0; k < MAXC; k++) run_cycle(1, 32'h8120_0010, 32'hB000_0000 + k, 4'hF, 1, 0, 0, exp_q.size() > 0, 0);
    check("credits_zero", out_credits_o, 0);
    check("ready_at_zero", ready_o, 0);
    run_cycle(1, 32'h8120_0010, 32'hB000_0100, 4'hF, 1, 0, 0, exp_q.size() > 0, 1);
    check("ready_after_credit", ready_o, 1);
    run_cycle(1, 32'h8120_0010, 32'hB000_0101, 4'hF, 1, 0, 0, 0, 1);
    check("credit_accept_same", out_credits_o, 1);
    idle(1, 0);

    // Swap to a local address is dropped and sets the sticky error.
    run_cycle(1, 32'h0000_0040, 32'h0, 4'hF, 0, 1, 0, 0, 0);
    check("swap_local_error", error_o, 1);
    check("swap_local_noenq", pkt_v_o, 0);
    run_cycle(1, 32'h0000_0040, 32'h0, 4'hF, 0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    check("error_sticky", error_o, 1);

    // Returning a credit with none outstanding saturates and flags an error.
    do_reset();
    idle(0, 0);
    idle(0, 1);
    check("overflow_credits", out_credits_o, MAXC);
    check("overflow_error", error_o, 1);

    // Reset in the middle of a cycle with two packets buffered.
    do_reset();
    idle(0, 0);
    run_cycle(1, 32'h8120_0010, 32'hC000_0000, 4'hF, 1, 0, 0, 0, 0);
    run_cycle(1, 32'h8120_0010, 32'hC000_0001, 4'hF, 1, 0, 0, 0, 0);
    do_reset();
    idle(0, 0);

    // Three yumis.
    for (int k = 0; k < 4; k++) run_cycle(k < 3, 32'h8120_0010, 32'hD000_0000 + k, 4'hF, 1, 0, 0, exp_q.size() > 0, 0);
    check("stats_three", stats_sent_o, STATS3);

    // Random traffic against the model.
    do_reset();
    idle(0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      bit aq, rl, cr, yu;
      a  = $urandom;
      aq = ($urandom_range(15) == 0);
      rl = ($urandom_range(15) == 0);
      cr = ($urandom_range(2) == 0) && (cred_m < MAXC);
      yu = ($urandom_range(1) == 0) && (exp_q.size() > 0);
      my_x_i = 4'($urandom); my_y_i = 4'($urandom);
      run_cycle($urandom_range(3) != 0, a, $urandom, 4'($urandom), $urandom_range(1) == 1, aq, rl, yu, cr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pkt_encode_buffered.md
BSG_MANYCORE_PKT_ENCODE_BUFFERED -- requirements
Module: bsg_manycore_pkt_encode_buffered

Interface
REQ-001 SHALL have parameter x_cord_width_p, default -1 (must be overridden), destination/source X coordinate width.
REQ-002 SHALL have parameter y_cord_width_p, default -1 (must be overridden), Y coordinate width.
REQ-003 SHALL have parameter data_width_p, default -1 (must be overridden), payload width, multiple of 8.
REQ-004 SHALL have parameter addr_width_p, default -1 (must be overridden), packet address field width.
REQ-005 SHALL have parameter els_p, default 2, output buffer depth, >=2.
REQ-006 SHALL have parameter max_out_credits_p, default 16, outstanding remote request limit, >=1.
REQ-007 SHALL have one clock and reset: clk_i (input, 1, rising-edge clock); reset_i (input, 1, asynchronous, active-high).
REQ-008 SHALL have request ports: v_i (in, 1); ready_o (out, 1); addr_i (in, 32, full address); data_i (in, data_width_p); mask_i (in, data_width_p/8); we_i, swap_aq_i, swap_rl_i (in, 1 each).
REQ-009 SHALL have my_x_i (in, x_cord_width_p) and my_y_i (in, y_cord_width_p), the source coordinates.
REQ-010 SHALL have local_v_o (out, 1): the request targets local memory.
REQ-011 SHALL have packet ports: pkt_v_o (out, 1); pkt_o (out, packet width from the shared macro); pkt_yumi_i (in, 1, consumes head).
REQ-012 SHALL have credit ports: credit_v_i (in, 1, one credit returned); out_credits_o (out, $clog2(max_out_credits_p+1)).
REQ-013 SHALL have error_o (out, 1, sticky) and stats_sent_o (out, 32).

Function
REQ-014 Address decode SHALL be: bit 31 remote; then y_cord; then x_cord; then addr field. pkt.addr SHALL be the low addr_width_p bits of the addr field.
REQ-015 Opcode priority SHALL be swap_aq > swap_rl > we (store) > load. op_ex SHALL be mask_i. src_x/src_y SHALL come from my_x_i/my_y_i.
REQ-016 ready_o SHALL be (buffer not full) AND (credits != 0), independent of addr_i and of pkt_yumi_i.
REQ-017 A remote request (v_i & remote) SHALL be accepted on a cycle where ready_o=1; the encoded packet SHALL be enqueued at that edge; pkt_v_o SHALL rise the following cycle (latency 1).
REQ-018 local_v_o SHALL be combinational: v_i & ~remote & ~swap_aq_i & ~swap_rl_i. A local request SHALL NOT touch buffer or credits.
REQ-019 A swap to a non-remote address with v_i=1 SHALL be dropped and SHALL set error_o until reset.
REQ-020 The buffer SHALL be FIFO-ordered. pkt_v_o SHALL equal not-empty. pkt_yumi_i SHALL be asserted only while pkt_v_o=1. Enqueue and dequeue in the same cycle SHALL both take effect.
REQ-021 Credit count SHALL decrement on remote accept and increment on credit_v_i. When both occur in the same cycle, the count SHALL remain unchanged.
REQ-022 credit_v_i when count==max_out_credits_p with no accept SHALL leave the count saturated and SHALL set error_o.
REQ-023 When count==0, ready_o SHALL be 0. A credit_v_i in that cycle SHALL make ready_o=1 the next cycle.

Reset
REQ-024 On reset_i assertion, asynchronously: buffer empty, pkt_v_o=0, out_credits_o=max_out_credits_p, error_o=0, stats_sent_o=0. Packets in flight mid-operation SHALL be discarded.
REQ-025 For the first rising edge after deassertion, outputs SHALL hold their reset values.

Configuration
REQ-026 With BSG_MANYCORE_PKT_ENCODE_STATS_EN defined, stats_sent_o SHALL count pkt_yumi_i events and wrap at 2^32.
REQ-027 Without BSG_MANYCORE_PKT_ENCODE_STATS_EN, stats_sent_o SHALL be tied to 0 and no counter SHALL be built.

Structure
REQ-028 Opcode constants, addr struct and packet struct macros SHALL come from the shared bsg_manycore_pkg / packet header. No local redefinition is allowed.
REQ-029 The buffer SHALL be instantiated as the library sub-module bsg_fifo_1r1w_small. Credit tracking SHALL be an inline up/down counter.

Verification (x=y=4, addr_width_p=20, data_width_p=32)
REQ-030 Store, addr_i=0x8120_0010, data=0xDEADBEEF, mask=0xF, my=(1,3): next cycle pkt_v_o=1, op=store, y=0, x=2, addr=0x00010, src=(1,3), credits=15.
REQ-031 Four remote accepts with els_p=2 and no yumi: ready_o=0 after the 2nd accept. Yumi one: exactly one more accept. Packets emerge in order.
REQ-032 max_out_credits_p=2, two accepts plus yumi: ready_o=0. credit_v_i pulse: ready_o=1 next cycle. Credit+accept same cycle: count unchanged.
REQ-033 swap_aq_i=1 to addr_i=0x0000_0040: no enqueue, local_v_o=0, error_o=1 persists until reset. Load to same addr: local_v_o=1.
REQ-034 Assert reset_i mid-cycle with 2 packets buffered: pkt_v_o=0 immediately (async), credits=16. With STATS_EN: 3 yumis give stats_sent_o=3. Without: stats_sent_o=0.
